// File: rtl/gain_scheduler.sv
// Stereo gain stage: one shared signed multiplier scales left then right,
// with round-half-up, saturation and per-channel bypass.
module gain_scheduler #(
  parameter int DW   = 24,
  parameter int GW   = 16,
  parameter int FRAC = 14
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic signed [DW-1:0] ldata,
  input  logic signed [DW-1:0] rdata,
  input  logic                 dvalid,
  input  logic signed [GW-1:0] gain_l,
  input  logic signed [GW-1:0] gain_r,
  input  logic                 bypass_l,
  input  logic                 bypass_r,
  input  logic                 clr_ovr,
  output logic signed [DW-1:0] lout,
  output logic signed [DW-1:0] rout,
  output logic                 ovalid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int PW = DW + GW;
  localparam int RW = PW + 1;
  localparam logic signed [RW-1:0] RND  = RW'(1) << (FRAC - 1);
  localparam logic signed [RW-1:0] MAXV = {{(GW + 1){1'b0}}, 1'b0, {(DW - 1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(GW + 1){1'b1}}, 1'b1, {(DW - 1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_L = 3'd1,
    SAT_L = 3'd2,
    MUL_R = 3'd3,
    SAT_R = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_dvPrev;
  logic signed [DW-1:0]  r_capL;
  logic signed [DW-1:0]  r_capR;
  logic signed [GW-1:0]  r_gainL;
  logic signed [GW-1:0]  r_gainR;
  logic                  r_bypL;
  logic                  r_bypR;
  logic signed [PW-1:0]  r_prod;
  logic signed [DW-1:0]  r_resL;

  logic                  w_start;
  logic signed [PW-1:0]  w_mulA;
  logic signed [PW-1:0]  w_mulB;
  logic signed [PW-1:0]  w_prod;
  logic signed [RW-1:0]  w_rnd;
  logic signed [RW-1:0]  w_shift;
  logic signed [DW-1:0]  w_sat;

  assign w_start = dvalid & ~r_dvPrev;

  // Operand steering for the single multiplier: right channel only in MUL_R.
  assign w_mulA  = (r_state == MUL_R) ? PW'(r_capR)  : PW'(r_capL);
  assign w_mulB  = (r_state == MUL_R) ? PW'(r_gainR) : PW'(r_gainL);
  assign w_prod  = w_mulA * w_mulB;

  assign w_rnd   = RW'(r_prod) + RND;
  assign w_shift = w_rnd >>> FRAC;

  always_comb begin
    w_sat = w_shift[DW-1:0];
    if (w_shift > MAXV) begin
      w_sat = MAXV[DW-1:0];
    end else if (w_shift < MINV) begin
      w_sat = MINV[DW-1:0];
    end
  end

  // Results are loaded on the SAT_R->DONE edge so they are visible together with ovalid in DONE.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_dvPrev <= 1'b0;
      lout     <= '0;
      rout     <= '0;
      ovalid   <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      r_dvPrev <= dvalid;
      ovalid   <= 1'b0;

      if (w_start && busy) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_capL  <= ldata;
            r_capR  <= rdata;
            r_gainL <= gain_l;
            r_gainR <= gain_r;
            r_bypL  <= bypass_l;
            r_bypR  <= bypass_r;
            busy    <= 1'b1;
            r_state <= MUL_L;
          end
        end
        MUL_L: begin
          r_prod  <= w_prod;
          r_state <= SAT_L;
        end
        SAT_L: begin
          r_resL  <= r_bypL ? r_capL : w_sat;
          r_state <= MUL_R;
        end
        MUL_R: begin
          r_prod  <= w_prod;
          r_state <= SAT_R;
        end
        SAT_R: begin
          lout    <= r_resL;
          rout    <= r_bypR ? r_capR : w_sat;
          ovalid  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gain_scheduler.sv
// Scoreboard bench for gain_scheduler: stimulus pushes expected results,
// a negedge monitor pops and compares whenever ovalid is seen.
module tb_gain_scheduler;

  logic        sclk = 1'b0;
  logic        rst;
  logic [23:0] ldata;
  logic [23:0] rdata;
  logic        dvalid;
  logic [15:0] gain_l;
  logic [15:0] gain_r;
  logic        bypass_l;
  logic        bypass_r;
  logic        clr_ovr;
  logic [23:0] lout;
  logic [23:0] rout;
  logic        ovalid;
  logic        busy;
  logic        overrun;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t monExp;
  logic monBusy;
  int   cycCnt = 0;
  int   lastN  = -100;
  bit   expOvr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  gain_scheduler #(.DW(24), .GW(16), .FRAC(14)) dut (
    .sclk     (sclk),
    .rst      (rst),
    .ldata    (ldata),
    .rdata    (rdata),
    .dvalid   (dvalid),
    .gain_l   (gain_l),
    .gain_r   (gain_r),
    .bypass_l (bypass_l),
    .bypass_r (bypass_r),
    .clr_ovr  (clr_ovr),
    .lout     (lout),
    .rout     (rout),
    .ovalid   (ovalid),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cycCnt <= cycCnt + 1;

  // Reference: Q2.14 multiply, round half toward +inf, clamp to 24-bit signed.
  function automatic logic [23:0] model(input logic signed [23:0] s,
                                        input logic signed [15:0] g,
                                        input bit byp);
    longint p;
    longint r;
    if (byp) return s;
    p = longint'(s) * longint'(g);
    r = (p + 64'sd8192) >>> 14;
    if (r > 64'sd8388607) r = 64'sd8388607;
    else if (r < -64'sd8388608) r = -64'sd8388608;
    return r[23:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cycCnt);
    end
  endtask

  function automatic logic [23:0] randSample();
    case ($urandom_range(0, 7))
      0:       return 24'h7FFFFF;
      1:       return 24'h800000;
      2:       return 24'($urandom_range(0, 15)) - 24'd8;
      default: return 24'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] randGain();
    case ($urandom_range(0, 5))
      0:       return 16'h4000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic scramble();
    ldata    = randSample();
    rdata    = randSample();
    gain_l   = randGain();
    gain_r   = randGain();
    bypass_l = 1'($urandom);
    bypass_r = 1'($urandom);
  endtask

  // Raises dvalid for 'hold' cycles with inputs scrambled after the rising edge.
  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r,
                               input logic [15:0] gl, input logic [15:0] gr,
                               input bit bl, input bit br, input bit clr,
                               input int hold, input int gap);
    @(negedge sclk);
    ldata    = l;
    rdata    = r;
    gain_l   = gl;
    gain_r   = gr;
    bypass_l = bl;
    bypass_r = br;
    clr_ovr  = clr;
    dvalid   = 1'b1;
    if (cycCnt >= lastN + 6) begin
      lastN = cycCnt;
      sb.push_back('{model(l, gl, bl), model(r, gr, br), cycCnt + 5});
      if (clr) expOvr = 1'b0;
    end else begin
      expOvr = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge sclk);
      clr_ovr = 1'b0;
      scramble();
    end
    dvalid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge sclk);
      scramble();
    end
    @(negedge sclk);
    checkOutput("overrun", 32'(overrun), 32'(expOvr));
  endtask

  task automatic clearOverrun();
    @(negedge sclk);
    clr_ovr = 1'b1;
    @(negedge sclk);
    clr_ovr = 1'b0;
    expOvr  = 1'b0;
    checkOutput("overrun_clr", 32'(overrun), 32'(expOvr));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_lout"},    32'(lout),    32'h0);
    checkOutput({tag, "_rout"},    32'(rout),    32'h0);
    checkOutput({tag, "_ovalid"},  32'(ovalid),  32'h0);
    checkOutput({tag, "_busy"},    32'(busy),    32'h0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  // A pass that is started and then killed by reset; nothing is expected from it.
  task automatic resetMidPass();
    @(negedge sclk);
    ldata  = 24'h3FFFFF;
    rdata  = 24'h012345;
    gain_l = 16'h4000;
    gain_r = 16'h4000;
    dvalid = 1'b1;
    lastN  = cycCnt;
    repeat (2) @(negedge sclk);
    rst = 1'b1;
    repeat (2) @(negedge sclk);
    checkResetState("rst_mid");
    sb.delete();
    lastN  = -100;
    expOvr = 1'b0;
    dvalid = 1'b0;
    rst    = 1'b0;
    @(negedge sclk);
  endtask

  always @(negedge sclk) begin
    if (!rst) begin
      monBusy = (cycCnt >= lastN + 1) && (cycCnt <= lastN + 5);
      checkOutput("busy", 32'(busy), 32'(monBusy));
      if (ovalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ovalid actual=1 required=0 at cycle %0d", cycCnt);
        end else begin
          monExp = sb.pop_front();
          checkOutput("lout",         32'(lout), 32'(monExp.l));
          checkOutput("rout",         32'(rout), 32'(monExp.r));
          checkOutput("ovalid_cycle", 32'(cycCnt), 32'(monExp.cyc));
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    dvalid   = 1'b0;
    clr_ovr  = 1'b0;
    ldata    = '0;
    rdata    = '0;
    gain_l   = '0;
    gain_r   = '0;
    bypass_l = 1'b0;
    bypass_r = 1'b0;
    repeat (3) @(negedge sclk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge sclk);

    $display("[TB] directed gain, saturation, rounding, bypass");
    applyStimulus(24'h100000, 24'hF00000, 16'h2000, 16'h4000, 1'b0, 1'b0, 1'b0, 1, 8);
    applyStimulus(24'h7FFFFF, 24'h800000, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0, 2, 8);
    applyStimulus(24'd3, -24'sd3, 16'h2000, 16'h2000, 1'b0, 1'b0, 1'b0, 1, 8);
    applyStimulus(24'h123456, 24'h0ABCDE, 16'h0000, 16'h6000, 1'b1, 1'b0, 1'b0, 4, 8);

    $display("[TB] reset mid-pass");
    resetMidPass();
    applyStimulus(24'h200000, 24'hE00000, 16'h4000, 16'h2000, 1'b0, 1'b0, 1'b0, 1, 8);

    $display("[TB] overrun and retrigger");
    applyStimulus(24'h000100, 24'h000200, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus(24'h111111, 24'h222222, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0, 1, 8);
    applyStimulus(24'h000300, 24'h000400, 16'h2000, 16'h2000, 1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus(24'h333333, 24'h444444, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1, 1, 8);
    clearOverrun();
    applyStimulus(24'h0F0F0F, 24'hF0F0F0, 16'h3000, 16'h5000, 1'b0, 1'b0, 1'b0, 20, 4);

    $display("[TB] randomized passes");
    for (int n = 0; n < 60; n++) begin
      applyStimulus(randSample(), randSample(), randGain(), randGain(),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0),
                    $urandom_range(1, 3), $urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) clearOverrun();
    end

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge sclk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
